comparator_serial_accum: RTL and testbench

Bit-serial magnitude-comparator accumulator for N-bit operands. It sits directly downstream of the 1-bit data-flow comparator and consumes that comparator's per-bit equal/greater/less outputs, presented MSB first, one bit per accepted cycle. It folds them into a single word-level eq/gt/lt verdict and returns the result over a valid/ready handshake. Its purpose is to compare wide operands with a single 1-bit comparator instance.

---
 rtl/comparator_pkg.sv | 32 +++
 rtl/comparator_bit_counter.sv | 39 +++
 rtl/comparator_serial_accum.sv | 171 +++++++++++++++++
 tb/tb_comparator_serial_accum.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_pkg
//  Description : Shared types and constants for the bit-serial comparator
//                accumulator: FSM state encoding and one-hot verdict codes
//                ordered {eq, gt, lt}.
//  Revision    : 1.0 - initial release
// ============================================================================
package comparator_pkg;

    // Accumulator controller states, binary encoded
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Word verdict, bit order matches the e,g,l input ordering
    typedef logic [2:0] res_t;

    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_EQ   = 3'b100;
    localparam res_t RES_GT   = 3'b010;
    localparam res_t RES_LT   = 3'b001;

    // True when exactly one of the three per-bit indications is set
    function automatic logic is_onehot3(input logic e, input logic g, input logic l);
        return ({e, g, l} == RES_EQ) || ({e, g, l} == RES_GT) || ({e, g, l} == RES_LT);
    endfunction

endpackage : comparator_pkg
`default_nettype wire

// File: rtl/comparator_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_bit_counter
//  Description : Counts accepted bit results of one comparison. Cleared on
//                start, saturates at N. Flags the last bit position (N-1)
//                and the terminal count (N).
//  Revision    : 1.0 - initial release
// ============================================================================
module comparator_bit_counter #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic last,
    output logic term
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] r_cnt;

    // Bit counter: clear has priority, increment stops at N so it never wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !term) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign last = (r_cnt == CW'(N - 1));
    assign term = (r_cnt == CW'(N));

endmodule : comparator_bit_counter
`default_nettype wire

// File: rtl/comparator_serial_accum.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_serial_accum
//  Description : Bit-serial magnitude comparator accumulator. Folds MSB-first
//                per-bit eq/gt/lt results into one word verdict returned over
//                a valid/ready handshake. All outputs are registered.
//                Optional illegal-input checking: COMP_SERIAL_ERR_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module comparator_serial_accum
    import comparator_pkg::*;
#(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic e_in,
    input  logic g_in,
    input  logic l_in,
    output logic busy,
    output logic res_valid,
    input  logic res_ready,
    output logic eq,
    output logic gt,
    output logic lt,
    output logic err
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_decided;
    logic   w_decided_nxt;
    logic   r_gt;
    logic   w_gt_nxt;
    logic   r_lt;
    logic   w_lt_nxt;
    logic   r_busy;
    logic   r_res_valid;
    res_t   r_res;
    res_t   w_res_nxt;
    logic   w_accept;
    logic   w_xfer;
    logic   w_start_acc;
    logic   w_last;
    logic   w_term;

    comparator_bit_counter #(
        .N (N)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start_acc),
        .inc   (w_accept),
        .last  (w_last),
        .term  (w_term)
    );

    // Next-state, verdict latch update and next registered outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_decided_nxt = r_decided;
        w_gt_nxt      = r_gt;
        w_lt_nxt      = r_lt;
        w_res_nxt     = RES_NONE;
        w_xfer        = (r_state == RESP) && res_ready;
        w_accept      = (r_state == ACCUM) && bit_valid && !w_term;
        w_start_acc   = start && ((r_state == IDLE) || w_xfer);

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt   = ACCUM;
                    w_decided_nxt = 1'b0;
                    w_gt_nxt      = 1'b0;
                    w_lt_nxt      = 1'b0;
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    // First differing bit decides; g wins over l, anything else is "equal"
                    if (!r_decided && (g_in || l_in)) begin
                        w_decided_nxt = 1'b1;
                        w_gt_nxt      = g_in;
                        w_lt_nxt      = !g_in;
                    end
                    if (w_last) begin
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                if (res_ready) begin
                    if (start) begin
                        w_state_nxt   = ACCUM;
                        w_decided_nxt = 1'b0;
                        w_gt_nxt      = 1'b0;
                        w_lt_nxt      = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_state_nxt == RESP) begin
            if (!w_decided_nxt) begin
                w_res_nxt = RES_EQ;
            end else if (w_gt_nxt) begin
                w_res_nxt = RES_GT;
            end else begin
                w_res_nxt = RES_LT;
            end
        end
    end

    // State, verdict latches and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_decided   <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res       <= RES_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_decided   <= w_decided_nxt;
            r_gt        <= w_gt_nxt;
            r_lt        <= w_lt_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_res_valid <= (w_state_nxt == RESP);
            r_res       <= w_res_nxt;
        end
    end

    assign busy      = r_busy;
    assign res_valid = r_res_valid;
    assign eq        = r_res[2];
    assign gt        = r_res[1];
    assign lt        = r_res[0];

`ifdef COMP_SERIAL_ERR_CHECK_EN
    logic r_err;

    // Sticky flag for accepted bits that are not exactly one-hot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_err <= 1'b0;
        end else if (w_accept && !is_onehot3(e_in, g_in, l_in)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    // e_in only feeds the checker; equal is implied when g and l are low
    logic w_unused_e;
    assign w_unused_e = e_in;
    assign err        = 1'b0;
`endif

endmodule : comparator_serial_accum
`default_nettype wire

// File: tb/tb_comparator_serial_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comparator_serial_accum
//  Description : Self-checking bench for comparator_serial_accum with N=4.
//                A transaction-level model (list of accepted bit codes,
//                first-difference verdict) predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator_serial_accum;
    import comparator_pkg::*;

    localparam int N = 4;
`ifdef COMP_SERIAL_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    // Bit codes kept by the model
    localparam logic [1:0] C_E = 2'd0;
    localparam logic [1:0] C_G = 2'd1;
    localparam logic [1:0] C_L = 2'd2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic bit_valid = 1'b0;
    logic e_in = 1'b0;
    logic g_in = 1'b0;
    logic l_in = 1'b0;
    logic res_ready = 1'b0;
    logic busy, res_valid, eq, gt, lt, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    comparator_serial_accum #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .e_in      (e_in),
        .g_in      (g_in),
        .l_in      (l_in),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt),
        .err       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Verdict of an MSB-first list of N codes: the first non-equal bit wins
    function automatic res_t verdict_of(input logic [2*N-1:0] codes);
        for (int i = N - 1; i >= 0; i--) begin
            if (codes[2*i +: 2] == C_G) return RES_GT;
            if (codes[2*i +: 2] == C_L) return RES_LT;
        end
        return RES_EQ;
    endfunction

    // Model: phase 0 idle, 1 collecting bits, 2 holding result
    int             m_phase = 0;
    int             m_n = 0;
    logic [2*N-1:0] m_codes = '0;
    logic           m_err = 1'b0;
    logic           m_live = 1'b0;
    logic           x_busy = 1'b0, x_valid = 1'b0, x_err = 1'b0;
    res_t           x_res = RES_NONE;

    always @(posedge clk) begin
        m_live = 1'b1;
        if (!rst_n) begin
            m_phase = 0;
            m_n     = 0;
            m_err   = 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_n = 0; m_codes = '0; m_err = 1'b0;
                end
                1: if (bit_valid) begin
                    m_codes = {m_codes[2*N-3:0], (g_in ? C_G : (l_in ? C_L : C_E))};
                    m_n++;
                    if ((int'(e_in) + int'(g_in) + int'(l_in)) != 1) m_err = 1'b1;
                    if (m_n == N) m_phase = 2;
                end
                default: if (res_ready) begin
                    if (start) begin
                        m_phase = 1; m_n = 0; m_codes = '0; m_err = 1'b0;
                    end else begin
                        m_phase = 0;
                    end
                end
            endcase
        end
        x_busy  = (m_phase != 0);
        x_valid = (m_phase == 2);
        x_res   = (m_phase == 2) ? verdict_of(m_codes) : RES_NONE;
        x_err   = ERR_EN & m_err;
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", busy, x_busy);
            chk("res_valid", res_valid, x_valid);
            chk("eq_gt_lt", {eq, gt, lt}, x_res);
            chk("err", err, x_err);
        end
    end

    // One cycle of stimulus: drive now, advance to the next falling edge
    task automatic cyc(input logic st, input logic bv, input logic e, input logic g,
                       input logic l, input logic rr);
        start = st; bit_valid = bv; e_in = e; g_in = g; l_in = l; res_ready = rr;
        @(negedge clk);
    endtask

    task automatic bit_e(); cyc(0, 1, 1, 0, 0, 0); endtask
    task automatic bit_g(); cyc(0, 1, 0, 1, 0, 0); endtask
    task automatic bit_l(); cyc(0, 1, 0, 0, 1, 0); endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [2*N-1:0] v;
        // Pin the model's verdict rule with hand-computed cases
        v = {C_E, C_E, C_G, C_L};
        chk("pin_model_gt", verdict_of(v), RES_GT);
        v = {C_L, C_E, C_E, C_E};
        chk("pin_model_lt", verdict_of(v), RES_LT);
        v = {C_E, C_E, C_E, C_E};
        chk("pin_model_eq", verdict_of(v), RES_EQ);

        // Reset
        repeat (2) cyc(0, 0, 0, 0, 0, 0);
        chk("reset_outputs", {busy, res_valid, eq, gt, lt, err}, 6'b0);
        rst_n = 1'b1;
        cyc(0, 1, 0, 1, 0, 1);                 // bit_valid ignored in IDLE
        chk("idle_ignores_bits", {busy, res_valid}, 2'b00);

        // Equal words: result in cycle 5
        cyc(1, 0, 0, 0, 0, 0);
        chk("busy_cycle1", busy, 1'b1);
        bit_e(); bit_e(); bit_e();
        chk("no_result_cycle4", res_valid, 1'b0);
        bit_e();
        chk("eq_result_cycle5", {res_valid, eq, gt, lt}, 4'b1100);
        cyc(0, 0, 0, 0, 0, 1);
        chk("eq_back_to_idle", {busy, res_valid}, 2'b00);

        // 1010 vs 1001: e,e,g,l -> gt, trailing l ignored
        cyc(1, 0, 0, 0, 0, 0);
        bit_e(); bit_e(); bit_g(); bit_l();
        chk("gt_result", {res_valid, eq, gt, lt}, 4'b1010);
        cyc(0, 0, 0, 0, 0, 1);

        // Stalls and backpressure: l,e,-,-,e,e -> lt in cycle 7
        cyc(1, 0, 0, 0, 0, 0);
        bit_l(); bit_e();
        cyc(0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0);
        bit_e();
        chk("stall_no_result_cycle6", res_valid, 1'b0);
        bit_e();
        chk("stall_result_cycle7", {res_valid, lt}, 2'b11);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 0, 0);
            chk("lt_held", {res_valid, eq, gt, lt}, 4'b1001);
        end
        cyc(0, 0, 0, 0, 0, 1);
        chk("stall_idle", {busy, res_valid}, 2'b00);

        // Back-to-back: e,e,e,e then start in transfer cycle, e,e,e,g
        cyc(1, 0, 0, 0, 0, 0);
        bit_e(); bit_e(); bit_e(); bit_e();
        cyc(1, 0, 0, 0, 0, 1);
        chk("b2b_busy_held", {busy, res_valid}, 2'b10);
        bit_e(); bit_e(); bit_e(); bit_g();
        chk("b2b_gt_result", {res_valid, eq, gt, lt}, 4'b1010);
        cyc(0, 0, 0, 0, 0, 1);

        // Reset mid-ACCUM after two bits, then a fresh comparison
        cyc(1, 0, 0, 0, 0, 0);
        bit_g(); bit_e();
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        chk("mid_reset_outputs", {busy, res_valid, eq, gt, lt, err}, 6'b0);
        rst_n = 1'b1;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);                 // all low counts as equal
        bit_l(); bit_g(); bit_e();
        chk("after_reset_lt", {res_valid, eq, gt, lt}, 4'b1001);
        cyc(0, 0, 0, 0, 0, 1);

        // Illegal bit g=l=1: gt verdict, sticky err only when checking is built
        cyc(1, 0, 0, 0, 0, 0);
        bit_e();
        cyc(0, 1, 0, 1, 1, 0);
        bit_e(); bit_e();
        chk("err_gt_result", {res_valid, eq, gt, lt}, 4'b1010);
        chk("err_flag", err, ERR_EN);
        cyc(1, 0, 0, 0, 0, 0);                 // start without transfer ignored
        cyc(0, 0, 0, 0, 0, 1);
        chk("err_sticky_idle", {busy, err}, {1'b0, ERR_EN});
        cyc(1, 0, 0, 0, 0, 0);
        chk("err_cleared_on_start", err, 1'b0);
        bit_e(); bit_e(); bit_e(); bit_l();
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_comparator_serial_accum
`default_nettype wire
